// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, deframes
// 11-bit frames (start, 8 data LSB-first, odd parity, stop) and filters
// the scan-code stream so only make codes of non-extended keys reach `code`.
// Break (F0) and extended (E0) prefixes are tracked and swallowed.
module ps2_scan_rx #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic            ps2c_s1_q, ps2c_s2_q, ps2c_prev_q;
    logic            ps2d_s1_q, ps2d_s2_q;
    logic            fall;

    state_t          state_q;
    logic [2:0]      bit_cnt_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [7:0]      shift_q;
    logic            par_ok_q;
    logic            brk_q, ext_q;
    logic [7:0]      code_q;
    logic            code_valid_q, frame_err_q;

    // Two-flop synchronisers plus a delayed copy of ps2_clk for edge detection;
    // idle-high reset values keep a released reset from looking like a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2c_s1_q   <= 1'b1;
            ps2c_s2_q   <= 1'b1;
            ps2c_prev_q <= 1'b1;
            ps2d_s1_q   <= 1'b1;
            ps2d_s2_q   <= 1'b1;
        end else begin
            ps2c_s1_q   <= ps2_clk;
            ps2c_s2_q   <= ps2c_s1_q;
            ps2c_prev_q <= ps2c_s2_q;
            ps2d_s1_q   <= ps2_data;
            ps2d_s2_q   <= ps2d_s1_q;
        end
    end

    assign fall = ps2c_prev_q & ~ps2c_s2_q;

    // Frame FSM with inactivity timeout and scan-code prefix filtering.
    // A fall always takes priority over the timeout terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            to_cnt_q     <= '0;
            shift_q      <= '0;
            par_ok_q     <= 1'b0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (fall) begin
                to_cnt_q <= '0;
                case (state_q)
                    IDLE: begin
                        if (!ps2d_s2_q) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {ps2d_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_ok_q <= ^{shift_q, ps2d_s2_q};
                        state_q  <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!(ps2d_s2_q && par_ok_q)) begin
                            frame_err_q <= 1'b1;
                            brk_q       <= 1'b0;
                            ext_q       <= 1'b0;
                        end else if (shift_q == 8'hF0) begin
                            brk_q <= 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_q <= 1'b1;
                        end else if (brk_q) begin
                            brk_q <= 1'b0;
                            ext_q <= 1'b0;
                        end else if (ext_q) begin
                            ext_q <= 1'b0;
                        end else begin
                            code_q       <= shift_q;
                            code_valid_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE) begin
                if (to_cnt_q == TO_LAST) begin
                    state_q     <= IDLE;
                    to_cnt_q    <= '0;
                    bit_cnt_q   <= '0;
                    frame_err_q <= 1'b1;
                    brk_q       <= 1'b0;
                    ext_q       <= 1'b0;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, the number of clk cycles without a ps2_clk falling edge that aborts a frame in progress.
REQ-002 SHALL have port clk, input, 1 bit, the system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port ps2_clk, input, 1 bit, the raw PS/2 keyboard clock, asynchronous to clk.
REQ-005 SHALL have port ps2_data, input, 1 bit, the raw PS/2 keyboard data, asynchronous to clk.
REQ-006 SHALL have port code, output, 8 bits, the last accepted make-code byte, i.e. the scan-code input of the letter-index decoder.
REQ-007 SHALL have port code_valid, output, 1 bit, a one-cycle pulse marking a new value on code.
REQ-008 SHALL have port frame_err, output, 1 bit, a one-cycle pulse on a discarded frame.

Function
REQ-009 SHALL pass ps2_clk and ps2_data through a 2-flop synchronizer each; all logic uses only the synchronized copies.
REQ-010 SHALL derive a fall strobe = previous synchronized ps2_clk high AND current low; all bit sampling occurs only on fall.
REQ-011 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-012 IDLE: on fall with data=0 (start bit) -> DATA, bit counter=0; on fall with data=1 -> stay IDLE, no error.
REQ-013 DATA: on each fall, shift data into the byte LSB-first and increment the counter; after the 8th bit -> PARITY.
REQ-014 PARITY: on fall, capture the parity bit -> STOP; parity is good iff XOR(8 data bits, parity bit)=1 (odd).
REQ-015 STOP: on fall -> IDLE; the frame is accepted iff the stop bit=1 and parity is good, otherwise frame_err pulses for one cycle.
REQ-016 SHALL count clk cycles since the last fall while not in IDLE; when the count reaches TIMEOUT_CYCLES, return to IDLE, discard the partial byte and pulse frame_err.
REQ-017 If fall and the timeout terminal count occur in the same cycle, fall SHALL win: the counter clears and no error is raised.
REQ-018 Accepted byte 0xF0: set the brk flag; no output.
REQ-019 Accepted byte 0xE0: set the ext flag; no output.
REQ-020 Any other accepted byte with brk=1 (key release) SHALL produce no output and clear brk and ext.
REQ-021 Any other accepted byte with ext=1 (extended key) SHALL produce no output and clear ext.
REQ-022 Any other accepted byte with brk=0 and ext=0 SHALL load code and pulse code_valid for exactly one cycle.
REQ-023 code_valid SHALL rise no later than 4 clk cycles after the ps2_clk falling edge of the stop bit.
REQ-024 code SHALL hold its value until the next code_valid.
REQ-025 Typematic repeats of the same make code SHALL each produce their own code_valid pulse.
REQ-026 Any frame_err SHALL clear brk and ext so decoding resynchronises.
REQ-027 code_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-028 While rst_n=0: code=0x00, code_valid=0, frame_err=0, FSM=IDLE, bit counter=0, timeout counter=0, brk=0, ext=0, synchronizer flops=1.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, the next start bit begins a fresh frame with no frame_err.

Verification
REQ-030 Frame 0x1C, parity 0, stop 1 -> code=0x1C, one code_valid pulse, no frame_err.
REQ-031 Bytes 0x1C, 0xF0, 0x1C -> exactly one code_valid (code=0x1C); brk=0 afterwards.
REQ-032 0x32 with parity 1 (bad) -> one frame_err pulse, no code_valid; then 0x21 with parity 1 -> code=0x21 with code_valid.
REQ-033 0x24 with stop bit 0 -> frame_err, code unchanged; 4 data bits then idle for TIMEOUT_CYCLES -> frame_err; then a full 0x24 frame -> code=0x24.
REQ-034 Bytes 0xE0, 0x75 -> no output; then 0x1A (parity 0) -> code=0x1A with code_valid.
REQ-035 rst_n pulsed low after 5 bits of a frame, then a full 0x1C frame -> code=0x1C, no frame_err.
